// File: rtl/conway_pkg.sv
// Shared encodings and default geometry for the Game-of-Life generation scheduler.
package conway_pkg;

  localparam int unsigned DEF_WIDTH_PIXELS  = 6;
  localparam int unsigned DEF_HEIGHT_PIXELS = 6;
  localparam int unsigned DEF_PIPE_LATENCY  = 3;
  localparam int unsigned DEF_RATE_WIDTH    = 4;
  localparam int unsigned DEF_GEN_WIDTH     = 16;
  localparam int unsigned PIX_CNT_WIDTH     = 6;
  localparam int unsigned FRAME_PIXELS      = DEF_WIDTH_PIXELS * DEF_HEIGHT_PIXELS;

  typedef enum logic [1:0] {
    CMD_STEP  = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_PAUSE = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_SWEEP     = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_SWAP_WAIT = 3'd4,
    ST_RATE_WAIT = 3'd5
  } sched_state_t;

endpackage

// File: rtl/generation_scheduler_if.sv
// Host command / display / sweep-controller signals of the generation scheduler.
// POPULATION_COUNT_EN adds the write-monitor inputs and the population output.
interface generation_scheduler_if #(
  parameter int unsigned RATE_WIDTH = 4,
  parameter int unsigned GEN_WIDTH  = 16
);
  logic                  cmd_valid;
  logic [1:0]            cmd_op;
  logic                  cmd_ready;
  logic [RATE_WIDTH-1:0] rate_div;
  logic                  vsync;
  logic                  sweep_stall;
  logic                  sweep_reset;
  logic                  sweep_enable;
  logic                  clear_mode;
  logic                  compute_buffer;
  logic                  display_buffer;
  logic                  running;
  logic                  busy;
  logic [GEN_WIDTH-1:0]  generation;
`ifdef POPULATION_COUNT_EN
  logic                               wr_strobe;
  logic                               wr_live;
  logic [conway_pkg::PIX_CNT_WIDTH-1:0] population;
`endif

  modport master (
    output cmd_valid, cmd_op, rate_div, vsync, sweep_stall,
`ifdef POPULATION_COUNT_EN
    output wr_strobe, wr_live,
    input  population,
`endif
    input  cmd_ready, sweep_reset, sweep_enable, clear_mode, compute_buffer,
    input  display_buffer, running, busy, generation
  );

  modport slave (
    input  cmd_valid, cmd_op, rate_div, vsync, sweep_stall,
`ifdef POPULATION_COUNT_EN
    input  wr_strobe, wr_live,
    output population,
`endif
    output cmd_ready, sweep_reset, sweep_enable, clear_mode, compute_buffer,
    output display_buffer, running, busy, generation
  );
endinterface

// File: rtl/vsync_rate_divider.sv
// Counts vsync pulses after a load and flags the max(rate,1)-th one.
module vsync_rate_divider #(
  parameter int unsigned RATE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [RATE_WIDTH-1:0] i_rate,
  input  logic                  i_enable,
  input  logic                  i_vsync,
  output logic                  o_terminal_c
);
  logic [RATE_WIDTH-1:0] r_target;
  logic [RATE_WIDTH-1:0] r_count;

  assign o_terminal_c = i_enable & i_vsync & (r_count == r_target - RATE_WIDTH'(1));

  // rate 0 behaves as 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target <= RATE_WIDTH'(1);
      r_count  <= '0;
    end else if (i_load) begin
      r_target <= (i_rate == '0) ? RATE_WIDTH'(1) : i_rate;
      r_count  <= '0;
    end else if (i_enable && i_vsync) begin
      r_count  <= o_terminal_c ? '0 : r_count + RATE_WIDTH'(1);
    end
  end
endmodule

// File: rtl/generation_scheduler.sv
// Sequences one generation: sweep one frame, drain the pipeline, swap buffers on vsync.
// Define POPULATION_COUNT_EN to add per-generation live-cell population counting.
module generation_scheduler
  import conway_pkg::*;
#(
  parameter int unsigned WIDTH_PIXELS  = DEF_WIDTH_PIXELS,
  parameter int unsigned HEIGHT_PIXELS = DEF_HEIGHT_PIXELS,
  parameter int unsigned PIPE_LATENCY  = DEF_PIPE_LATENCY,
  parameter int unsigned RATE_WIDTH    = DEF_RATE_WIDTH,
  parameter int unsigned GEN_WIDTH     = DEF_GEN_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  generation_scheduler_if.slave bus
);
  localparam int unsigned FRAME   = WIDTH_PIXELS * HEIGHT_PIXELS;
  localparam int unsigned DRAIN_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

  sched_state_t             r_state, w_state_nxt;
  logic [PIX_CNT_WIDTH-1:0] r_pix_cnt;
  logic [DRAIN_W-1:0]       r_drain_cnt;
  logic [GEN_WIDTH-1:0]     r_generation;
  logic                     r_running, r_clear_mode, r_display;
  logic w_cmd_ready, w_accept, w_pause, w_launch, w_sweep_en, w_last_pix, w_last_drain;
  logic w_swap, w_load_rate, w_rate_hit;

  vsync_rate_divider #(.RATE_WIDTH(RATE_WIDTH)) u_rate_div (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load_rate),
    .i_rate       (bus.rate_div),
    .i_enable     (r_state == ST_RATE_WAIT),
    .i_vsync      (bus.vsync),
    .o_terminal_c (w_rate_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    w_swap       = 1'b0;
    w_load_rate  = 1'b0;
    w_cmd_ready  = (r_state == ST_IDLE) || (bus.cmd_op == CMD_PAUSE);
    w_accept     = bus.cmd_valid & w_cmd_ready;
    w_pause      = w_accept & (bus.cmd_op == CMD_PAUSE);
    w_sweep_en   = (r_state == ST_SWEEP) & ~bus.sweep_stall;
    w_last_pix   = w_sweep_en & (r_pix_cnt == PIX_CNT_WIDTH'(FRAME - 1));
    w_last_drain = (r_drain_cnt == DRAIN_W'(PIPE_LATENCY - 1));
    case (r_state)
      ST_IDLE: if (w_accept && !w_pause) begin
        w_launch    = 1'b1;
        w_state_nxt = ST_START;
      end
      ST_START: w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (w_last_pix) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last_drain) w_state_nxt = ST_SWAP_WAIT;
      ST_SWAP_WAIT: if (bus.vsync) begin
        w_swap      = 1'b1;
        w_load_rate = r_running & ~w_pause;
        w_state_nxt = (r_running && !w_pause) ? ST_RATE_WAIT : ST_IDLE;
      end
      ST_RATE_WAIT: begin
        if (w_pause)         w_state_nxt = ST_IDLE;
        else if (w_rate_hit) w_state_nxt = ST_START;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_running    <= 1'b0;
      r_clear_mode <= 1'b0;
      r_display    <= 1'b0;
      r_generation <= '0;
      r_pix_cnt    <= '0;
      r_drain_cnt  <= '0;
    end else begin
      if (w_pause)                                 r_running <= 1'b0;
      else if (w_launch && bus.cmd_op == CMD_RUN)  r_running <= 1'b1;

      if (w_launch)    r_clear_mode <= (bus.cmd_op == CMD_CLEAR);
      else if (w_swap) r_clear_mode <= 1'b0;

      if (r_state == ST_START) r_pix_cnt <= '0;
      else if (w_sweep_en)     r_pix_cnt <= r_pix_cnt + PIX_CNT_WIDTH'(1);

      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;

      if (w_swap) begin
        r_display    <= ~r_display;
        r_generation <= r_clear_mode ? '0 : r_generation + GEN_WIDTH'(1);
      end
    end
  end

`ifdef POPULATION_COUNT_EN
  logic [PIX_CNT_WIDTH-1:0] r_pop_shadow, r_population;

  // shadow accumulates this generation's live writes; published at the swap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pop_shadow <= '0;
      r_population <= '0;
    end else begin
      if (r_state == ST_START)
        r_pop_shadow <= '0;
      else if ((r_state == ST_SWEEP || r_state == ST_DRAIN) && bus.wr_strobe && bus.wr_live)
        r_pop_shadow <= r_pop_shadow + PIX_CNT_WIDTH'(1);
      if (w_swap) r_population <= r_pop_shadow;
    end
  end
  assign bus.population = r_population;
`endif

  assign bus.cmd_ready      = w_cmd_ready;
  assign bus.sweep_reset    = (r_state == ST_START);
  assign bus.sweep_enable   = w_sweep_en;
  assign bus.clear_mode     = r_clear_mode;
  assign bus.compute_buffer = ~r_display;
  assign bus.display_buffer = r_display;
  assign bus.running        = r_running;
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.generation     = r_generation;
endmodule
